seg_scan_4digit: RTL and testbench

- Downstream display stage for the ping-pong counter.
- Consumes the two BCD digits (num1, num0) and the counter's control bits (en1 = hold, en2 = direction).
- Time-multiplexes a 4-digit common-anode seven-segment display:
  - digit3: direction glyph
  - digit2: pause flag
  - digit1/digit0: count
- Adds leading-zero blanking, a blink while paused, and tear-free per-frame input snapshots.

---
 rtl/seg_scan_4digit.sv | 141 ++++++++++++++
 tb/tb_seg_scan_4digit.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/seg_scan_4digit.sv
// seg_scan_4digit: 4-digit common-anode seven-segment scanner
// for the ping-pong counter (direction, pause, two BCD digits).
module seg_scan_4digit #(
  parameter int SCAN_DIV     = 25000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] num1,
  input  logic [3:0] num0,
  input  logic       en1,
  input  logic       en2,
  output logic [3:0] an,
  output logic [7:0] seg
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int FW =
    (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FR_LAST  = FW'(BLINK_FRAMES - 1);

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_UP    = 8'hFE;
  localparam logic [7:0] SEG_DOWN  = 8'hF7;
  localparam logic [7:0] SEG_P     = 8'h8C;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          blink_q, blink_d;
  logic [3:0]    s_num1_q, s_num1_d;
  logic [3:0]    s_num0_q, s_num0_d;
  logic          s_en1_q, s_en1_d;
  logic          s_en2_q, s_en2_d;
  logic [3:0]    an_q, an_d;
  logic [7:0]    seg_q, seg_d;

  logic          tick;
  logic          frame_end;
  logic          dark;
  logic [7:0]    code;

  function automatic logic [7:0] bcd7(input logic [3:0] d);
    logic [7:0] r;
    r = SEG_DASH;
    case (d)
      4'd0: r = 8'hC0;
      4'd1: r = 8'hF9;
      4'd2: r = 8'hA4;
      4'd3: r = 8'hB0;
      4'd4: r = 8'h99;
      4'd5: r = 8'h92;
      4'd6: r = 8'h82;
      4'd7: r = 8'hF8;
      4'd8: r = 8'h80;
      4'd9: r = 8'h90;
      default: r = SEG_DASH;
    endcase
    return r;
  endfunction

  assign tick      = (cnt_q == CNT_LAST);
  assign frame_end = tick && (idx_q == 2'd3);
  assign dark      = s_en1_q && blink_q;

  // Glyph for the slot currently selected by idx.
  always_comb begin
    code = SEG_BLANK;
    case (idx_q)
      2'd3: code = s_en2_q ? SEG_UP : SEG_DOWN;
      2'd2: code = s_en1_q ? SEG_P : SEG_BLANK;
      2'd1: code = (dark || s_num1_q == 4'd0)
                   ? SEG_BLANK : bcd7(s_num1_q);
      default: code = dark ? SEG_BLANK : bcd7(s_num0_q);
    endcase
  end

  // Next state: prescaler, slot, frame/blink, snapshot, outputs.
  always_comb begin
    cnt_d    = tick ? '0 : cnt_q + 1'b1;
    idx_d    = idx_q;
    fcnt_d   = fcnt_q;
    blink_d  = blink_q;
    s_num1_d = s_num1_q;
    s_num0_d = s_num0_q;
    s_en1_d  = s_en1_q;
    s_en2_d  = s_en2_q;
    an_d     = ~(4'b0001 << idx_q);
    seg_d    = code;
    if (tick) begin
      idx_d = idx_q + 2'd1;
      an_d  = 4'b1111;
      seg_d = SEG_BLANK;
    end
    if (frame_end) begin
      s_num1_d = num1;
      s_num0_d = num0;
      s_en1_d  = en1;
      s_en2_d  = en2;
      if (fcnt_q == FR_LAST) begin
        fcnt_d  = '0;
        blink_d = ~blink_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      idx_q    <= 2'd0;
      fcnt_q   <= '0;
      blink_q  <= 1'b0;
      s_num1_q <= 4'd0;
      s_num0_q <= 4'd0;
      s_en1_q  <= 1'b0;
      s_en2_q  <= 1'b1;
      an_q     <= 4'b1111;
      seg_q    <= SEG_BLANK;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      fcnt_q   <= fcnt_d;
      blink_q  <= blink_d;
      s_num1_q <= s_num1_d;
      s_num0_q <= s_num0_d;
      s_en1_q  <= s_en1_d;
      s_en2_q  <= s_en2_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule

// File: tb/tb_seg_scan_4digit.sv
// tb_seg_scan_4digit: directed checks of scan order, blanking,
// snapshots, pause blink and mid-slot reset (SCAN_DIV=4, BLINK=2).
module tb_seg_scan_4digit;

  logic       clk;
  logic       rst;
  logic [3:0] num1;
  logic [3:0] num0;
  logic       en1;
  logic       en2;
  logic [3:0] an;
  logic [7:0] seg;

  int total;
  int passed;
  int failed;

  seg_scan_4digit #(
    .SCAN_DIV    (4),
    .BLINK_FRAMES(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .num1(num1),
    .num0(num0),
    .en1 (en1),
    .en2 (en2),
    .an  (an),
    .seg (seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then compare on the falling edge.
  task automatic samp(input string tag,
                      input logic [3:0] ea,
                      input logic [7:0] es);
    @(negedge clk);
    total++;
    assert ({an, seg} === {ea, es}) passed++;
    else begin
      failed++;
      $error("FAIL %s: an/seg=%b/%h expected %b/%h",
             tag, an, seg, ea, es);
    end
  endtask

  // One slot: 3 driven cycles then the blank cycle.
  task automatic slot(input string tag,
                      input int s,
                      input logic [7:0] c);
    logic [3:0] ea;
    ea = ~(4'b0001 << s);
    for (int i = 0; i < 3; i++)
      samp($sformatf("%s.s%0d.%0d", tag, s, i), ea, c);
    samp($sformatf("%s.s%0d.blank", tag, s), 4'b1111, 8'hFF);
  endtask

  task automatic frame(input string tag,
                       input logic [7:0] c0,
                       input logic [7:0] c1,
                       input logic [7:0] c2,
                       input logic [7:0] c3);
    slot(tag, 0, c0);
    slot(tag, 1, c1);
    slot(tag, 2, c2);
    slot(tag, 3, c3);
  endtask

  initial begin
    total  = 0;
    passed = 0;
    failed = 0;
    rst  = 1'b1;
    num1 = 4'd0;
    num0 = 4'd0;
    en1  = 1'b0;
    en2  = 1'b1;

    // Reset held three cycles: dark display.
    samp("rst0", 4'b1111, 8'hFF);
    samp("rst1", 4'b1111, 8'hFF);
    samp("rst2", 4'b1111, 8'hFF);
    rst = 1'b0;

    // Scan order: frame 0 shows the reset snapshot.
    num1 = 4'd6;
    num0 = 4'd0;
    frame("f0", 8'hC0, 8'hFF, 8'hFF, 8'hFE);
    frame("f1", 8'hC0, 8'h82, 8'hFF, 8'hFE);

    // Tear-free snapshot: change is deferred a frame.
    num0 = 4'd5;
    frame("f2", 8'hC0, 8'h82, 8'hFF, 8'hFE);
    slot("f3", 0, 8'h92);
    num0 = 4'd4;
    slot("f3", 1, 8'h82);
    slot("f3", 2, 8'hFF);
    slot("f3", 3, 8'hFE);
    frame("f4", 8'h99, 8'h82, 8'hFF, 8'hFE);

    // Pause blink, direction down.
    en1  = 1'b1;
    num1 = 4'd3;
    num0 = 4'd7;
    en2  = 1'b0;
    frame("f5", 8'h99, 8'h82, 8'hFF, 8'hFE);
    frame("f6", 8'hFF, 8'hFF, 8'h8C, 8'hF7);
    frame("f7", 8'hFF, 8'hFF, 8'h8C, 8'hF7);
    frame("f8", 8'hF8, 8'hB0, 8'h8C, 8'hF7);
    frame("f9", 8'hF8, 8'hB0, 8'h8C, 8'hF7);
    frame("f10", 8'hFF, 8'hFF, 8'h8C, 8'hF7);

    // Leading-zero blank, then non-BCD dashes.
    en1  = 1'b0;
    en2  = 1'b1;
    num1 = 4'd0;
    num0 = 4'd9;
    frame("f11", 8'hFF, 8'hFF, 8'h8C, 8'hF7);
    frame("f12", 8'h90, 8'hFF, 8'hFF, 8'hFE);
    num1 = 4'hA;
    num0 = 4'hF;
    en2  = 1'b0;
    frame("f13", 8'h90, 8'hFF, 8'hFF, 8'hFE);
    frame("f14", 8'hBF, 8'hBF, 8'hFF, 8'hF7);

    // Reset while digit 2 is lit.
    slot("f15", 0, 8'hBF);
    slot("f15", 1, 8'hBF);
    samp("f15.s2.0", 4'b1011, 8'hFF);
    rst = 1'b1;
    samp("midrst", 4'b1111, 8'hFF);
    rst = 1'b0;
    frame("r0", 8'hC0, 8'hFF, 8'hFF, 8'hFE);
    frame("r1", 8'hBF, 8'hBF, 8'hFF, 8'hF7);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
